// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer and its helpers: default sizes,
// sequencer state encoding and the opcode values understood by the ALU.
package alu_pkg;

    localparam int unsigned WIDTH_DEF   = 4;
    localparam int unsigned OPW_DEF     = 3;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned ITER_W      = 4;
    localparam int unsigned WDOG_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_e;

    localparam logic [OPW_DEF-1:0] OP_ADD   = 3'd0;
    localparam logic [OPW_DEF-1:0] OP_SUB   = 3'd1;
    localparam logic [OPW_DEF-1:0] OP_AND   = 3'd2;
    localparam logic [OPW_DEF-1:0] OP_OR    = 3'd3;
    localparam logic [OPW_DEF-1:0] OP_XOR   = 3'd4;
    localparam logic [OPW_DEF-1:0] OP_PASSA = 3'd5;
    localparam logic [OPW_DEF-1:0] OP_PASSB = 3'd6;
    localparam logic [OPW_DEF-1:0] OP_NOTA  = 3'd7;

endpackage

// File: rtl/alu_watchdog.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT-1.
module alu_watchdog
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [WDOG_W-1:0] count_q;
    logic [WDOG_W-1:0] count_d;

    assign expired_c = (count_q == WDOG_W'(TIMEOUT - 1));

    // Holds at the expiry value so a late consumer still sees it.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expired_c) begin
            count_d = count_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one or a chain of ALU operations over a registered A/B operand
// pair, writing each result back and guarding the ALU handshake with a watchdog.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned OPW     = OPW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   data_AB,
    input  logic [OPW-1:0]       op_in,
    input  logic                 pos_save,
    input  logic [ITER_W-1:0]    iter,
    output logic [OPW-1:0]       alu_op,
    output logic [WIDTH-1:0]     alu_opA,
    output logic [WIDTH-1:0]     alu_opB,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [WIDTH-1:0]     alu_result,
    output logic [WIDTH-1:0]     data_outA,
    output logic [WIDTH-1:0]     data_outB,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

    seq_state_e          state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [OPW-1:0]      op_q, op_d;
    logic                pos_q, pos_d;
    logic [ITER_W-1:0]   rem_q, rem_d;
    logic                terr_q, terr_d;
    logic                alu_start_q, alu_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wd_clr_c;
    logic                wd_en_c;
    logic                wd_expired_c;

    alu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (wd_clr_c),
        .en        (wd_en_c),
        .expired_c (wd_expired_c)
    );

    // Next-state and datapath; pulse outputs are decoded from the next state
    // so they leave a flop aligned with the state they belong to.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        pos_d    = pos_q;
        rem_d    = rem_q;
        terr_d   = terr_q;
        wd_clr_c = 1'b0;
        wd_en_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (pos_save) begin
                        a_d = data_AB[2*WIDTH-1:WIDTH];
                        b_d = data_AB[WIDTH-1:0];
                    end else begin
                        a_d = data_AB[WIDTH-1:0];
                        b_d = data_AB[2*WIDTH-1:WIDTH];
                    end
                    op_d    = op_in;
                    pos_d   = pos_save;
                    rem_d   = (iter == ITER_W'(0)) ? ITER_W'(1) : iter;
                    terr_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_clr_c = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_done) begin
                    if (pos_q) begin
                        a_d = alu_result;
                    end else begin
                        b_d = alu_result;
                    end
                    rem_d   = rem_q - ITER_W'(1);
                    state_d = (rem_d != ITER_W'(0)) ? ST_ISSUE : ST_FINISH;
                end else if (wd_expired_c) begin
                    // Abandon the rest of the chain; operands stay as they were.
                    terr_d  = 1'b1;
                    rem_d   = '0;
                    state_d = ST_FINISH;
                end else begin
                    wd_en_c = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        alu_start_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            pos_q       <= 1'b0;
            rem_q       <= '0;
            terr_q      <= 1'b0;
            alu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            pos_q       <= pos_d;
            rem_q       <= rem_d;
            terr_q      <= terr_d;
            alu_start_q <= alu_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign alu_op      = op_q;
    assign alu_opA     = a_q;
    assign alu_opB     = b_q;
    assign data_outA   = a_q;
    assign data_outB   = b_q;
    assign alu_start   = alu_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule
